pipelined_tree_adder: RTL



---
 rtl/dic_pkg.sv | 30 +++
 rtl/tree_add_level.sv | 47 ++++
 rtl/pipelined_tree_adder.sv | 101 ++++++++++
 3 files changed

// File: rtl/dic_pkg.sv
// Shared helpers for the adder tree: width arithmetic, saturation bounds and
// the per-beat mode sideband that rides alongside the data.
package dic_pkg;

  typedef struct packed {
    logic sat;
    logic rnd;
  } mode_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int lvl_w(input int in_w, input int l);
    return in_w + l;
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/tree_add_level.sv
// One registered tree level: node j = in 2j + in 2j+1, one bit wider,
// with valid and mode sideband held whenever the enable is low.
module tree_add_level
  import dic_pkg::*;
#(
  parameter int N_NODES = 2,
  parameter int W_IN    = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             en_i,
  input  logic                             vld_i,
  input  mode_t                            mode_i,
  input  logic [N_NODES-1:0][W_IN-1:0]     d_i,
  output logic                             vld_o,
  output mode_t                            mode_o,
  output logic [N_NODES/2-1:0][W_IN:0]     q_o
);
  localparam int N_OUT = N_NODES / 2;

  logic [N_OUT-1:0][W_IN:0] q_d, q_q;
  logic                     vld_q;
  mode_t                    mode_q;

  always_comb begin
    q_d = '0;
    for (int j = 0; j < N_OUT; j++)
      q_d[j] = {d_i[2*j][W_IN-1], d_i[2*j]} + {d_i[2*j+1][W_IN-1], d_i[2*j+1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      vld_q  <= 1'b0;
      mode_q <= '0;
    end else if (en_i) begin
      q_q    <= q_d;
      vld_q  <= vld_i;
      mode_q <= mode_i;
    end
  end

  assign q_o    = q_q;
  assign vld_o  = vld_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/pipelined_tree_adder.sv
// Pipelined signed adder tree: masked lanes reduced one level per stage, then
// an output stage that rounds, shifts, flags overflow and optionally saturates.
module pipelined_tree_adder
  import dic_pkg::*;
#(
  parameter int NUM_IN     = 32,
  parameter int IN_W       = 36,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*IN_W-1:0]   in_data,
  input  logic [NUM_IN-1:0]        in_mask,
  input  logic                     in_round,
  input  logic                     in_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_result,
  output logic                     out_ovf
);
  localparam int LEVELS = clog2(NUM_IN);
  localparam int STAGES = LEVELS + 1;
  localparam int SW     = lvl_w(IN_W, LEVELS);
  localparam int RSH    = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [SW:0] RND_C = (FRAC_SHIFT > 0) ? ((SW+1)'(1) << RSH) : '0;
  localparam logic signed [SW:0] S_MAX = (SW+1)'(sat_max(OUT_W));
  localparam logic signed [SW:0] S_MIN = (SW+1)'(sat_min(OUT_W));

  logic                           advance;
  logic [STAGES:0]                vld_pipe;
  mode_t [LEVELS:0]               mode_pipe;
  logic [NUM_IN-1:0][IN_W-1:0]    lane_m;

  logic                           out_valid_q;
  logic [OUT_W-1:0]               out_result_q, out_result_d;
  logic                           out_ovf_q, out_ovf_d;

  // Full-pipeline stall: every stage moves together or not at all.
  assign advance      = !out_valid_q || out_ready;
  assign in_ready     = advance;
  assign vld_pipe[0]  = in_valid;
  assign mode_pipe[0] = {in_sat, in_round};
  assign vld_pipe[STAGES] = out_valid_q;

  always_comb begin
    lane_m = '0;
    for (int k = 0; k < NUM_IN; k++)
      lane_m[k] = in_mask[k] ? in_data[k*IN_W +: IN_W] : '0;
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    logic [(NUM_IN>>l)-1:0][lvl_w(IN_W, l)-1:0] q;
    if (l == 1) begin : g_in
      tree_add_level #(.N_NODES(NUM_IN), .W_IN(IN_W)) u_lvl (
        .clk, .reset_n, .en_i(advance),
        .vld_i(vld_pipe[0]), .mode_i(mode_pipe[0]), .d_i(lane_m),
        .vld_o(vld_pipe[1]), .mode_o(mode_pipe[1]), .q_o(q)
      );
    end else begin : g_mid
      tree_add_level #(.N_NODES(NUM_IN >> (l-1)), .W_IN(lvl_w(IN_W, l-1))) u_lvl (
        .clk, .reset_n, .en_i(advance),
        .vld_i(vld_pipe[l-1]), .mode_i(mode_pipe[l-1]), .d_i(g_lvl[l-1].q),
        .vld_o(vld_pipe[l]), .mode_o(mode_pipe[l]), .q_o(q)
      );
    end
  end

  logic signed [SW-1:0] sum;
  logic signed [SW:0]   r_s, s_s;

  assign sum = $signed(g_lvl[LEVELS].q[0]);

  always_comb begin
    r_s          = {sum[SW-1], sum} + (mode_pipe[LEVELS].rnd ? RND_C : '0);
    s_s          = r_s >>> FRAC_SHIFT;
    out_ovf_d    = (s_s > S_MAX) || (s_s < S_MIN);
    out_result_d = s_s[OUT_W-1:0];
    if (mode_pipe[LEVELS].sat && out_ovf_d)
      out_result_d = s_s[SW] ? S_MIN[OUT_W-1:0] : S_MAX[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
    end else if (advance) begin
      out_valid_q  <= vld_pipe[LEVELS];
      out_result_q <= out_result_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;

endmodule
